can_rx_filter_fifo: RTL

- Parametrised receive back-end for the CAN controller.
- Accepts completed frames from the CAN receiver core and screens them through NFILT programmable ID/mask acceptance filters.
- Buffers accepted frames in a DEPTH-entry frame FIFO, replacing the single-frame receive buffer and overwrite flag.
- Sits between the receiver and the 32-bit peripheral bus, with its own register window and level IRQ.

---
 rtl/can_rx_filter_fifo_if.sv | 19 +
 rtl/can_rx_filter_fifo.sv | 118 +++++++++++
 2 files changed

// File: rtl/can_rx_filter_fifo_if.sv
// can_rx_filter_fifo_if: receiver frame strobe plus 32-bit register bus for the CAN RX filter FIFO.
interface can_rx_filter_fifo_if;
  logic        frm_valid;
  logic [28:0] frm_id;
  logic        frm_ext;
  logic        frm_rtr;
  logic [3:0]  frm_dlc;
  logic [63:0] frm_data;
  logic        cs;
  logic        wr;
  logic [4:0]  rs;
  logic [31:0] d;
  logic [31:0] q;
  logic        irq;
  modport master (output frm_valid, frm_id, frm_ext, frm_rtr, frm_dlc, frm_data, cs, wr, rs, d,
                  input q, irq);
  modport slave (input frm_valid, frm_id, frm_ext, frm_rtr, frm_dlc, frm_data, cs, wr, rs, d,
                 output q, irq);
endinterface

// File: rtl/can_rx_filter_fifo.sv
// can_rx_filter_fifo: ID/mask acceptance filters feeding a DEPTH-frame receive FIFO with register window and IRQ.
module can_rx_filter_fifo #(
  parameter int DEPTH = 4,
  parameter int NFILT = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst_n,
  can_rx_filter_fifo_if.slave bus
);
  localparam int AW = CW - 1;
  localparam int EW = 103;
  logic [28:0]      r_fid   [NFILT];
  logic [28:0]      r_fmask [NFILT];
  logic [NFILT-1:0] r_fen, r_fext, r_fextm;
  logic             r_s1_v;
  logic [EW-1:0]    r_s1;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [7:0]       r_ovf_cnt;
  logic [3:0]       r_wm;
  logic [2:0]       r_irqen;
  logic [NFILT-1:0] w_hit_vec;
  logic [2:0]       w_hit;
  logic             w_nm, w_acc;
  logic             w_wr_stat, w_empty, w_full, w_pop, w_flush, w_clr, w_in, w_push, w_drop;
  logic [EW-1:0]    w_head;
  logic [31:0]      w_q;
  // iterate high to low so the lowest-index hit wins
  always_comb begin
    w_hit_vec = '0;
    w_hit = '0;
    for (int k = NFILT - 1; k >= 0; k--) begin
      w_hit_vec[k] = r_fen[k] & (((bus.frm_id ^ r_fid[k]) & r_fmask[k]) == '0)
                     & (~r_fextm[k] | (bus.frm_ext == r_fext[k]));
      if (w_hit_vec[k]) w_hit = 3'(k);
    end
  end
  assign w_nm      = ~|r_fen;
  assign w_acc     = w_nm | (|w_hit_vec);
  assign w_wr_stat = bus.cs & bus.wr & (bus.rs == 5'd4);
  assign w_empty   = r_cnt == '0;
  assign w_full    = r_cnt == CW'(DEPTH);
  assign w_pop     = w_wr_stat & bus.d[0] & ~w_empty;
  assign w_flush   = w_wr_stat & bus.d[1];
  assign w_clr     = w_wr_stat & bus.d[2];
  assign w_in      = r_s1_v & ~w_flush;
  assign w_push    = w_in & (~w_full | w_pop);
  assign w_drop    = w_in & w_full & ~w_pop;
  assign w_head    = r_mem[r_rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
      r_wm      <= '0;
      r_irqen   <= '0;
      r_fen     <= '0;
      r_fext    <= '0;
      r_fextm   <= '0;
      for (int k = 0; k < NFILT; k++) begin
        r_fid[k]   <= '0;
        r_fmask[k] <= '0;
      end
    end else begin
      r_s1_v    <= bus.frm_valid & w_acc;
      r_wp      <= w_flush ? '0 : r_wp + AW'(w_push);
      r_rp      <= w_flush ? '0 : r_rp + AW'(w_pop);
      r_cnt     <= w_flush ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
      r_ovf     <= w_clr ? 1'b0 : r_ovf | w_drop;
      r_ovf_cnt <= w_clr ? '0 : r_ovf_cnt + 8'(w_drop & (r_ovf_cnt != 8'hFF));
      if (w_wr_stat) begin
        r_wm    <= bus.d[15:12];
        r_irqen <= bus.d[31:29];
      end
      for (int k = 0; k < NFILT; k++) begin
        if (bus.cs && bus.wr && bus.rs == 5'(8 + 2 * k)) begin
          r_fen[k]  <= bus.d[31];
          r_fext[k] <= bus.d[30];
          r_fid[k]  <= bus.d[28:0];
        end
        if (bus.cs && bus.wr && bus.rs == 5'(9 + 2 * k)) begin
          r_fextm[k] <= bus.d[30];
          r_fmask[k] <= bus.d[28:0];
        end
      end
    end
  end
  // entry layout: {hit, nomatch_any, ext, rtr, dlc, id, data}
  always_ff @(posedge clk) begin
    if (bus.frm_valid)
      r_s1 <= {w_hit, w_nm, bus.frm_ext, bus.frm_rtr, bus.frm_dlc, bus.frm_id, bus.frm_data};
    if (w_push) r_mem[r_wp] <= r_s1;
  end
  always_comb begin
    w_q = '0;
    if (bus.cs && !bus.wr) begin
      if (bus.rs == 5'd0 && !w_empty) w_q = {w_head[98], w_head[97], 1'b0, w_head[92:64]};
      if (bus.rs == 5'd1 && !w_empty) w_q = {w_head[102:100], 21'b0, w_head[99], 3'b0, w_head[96:93]};
      if (bus.rs == 5'd2 && !w_empty) w_q = w_head[31:0];
      if (bus.rs == 5'd3 && !w_empty) w_q = w_head[63:32];
      if (bus.rs == 5'd4)
        w_q = {r_irqen, 5'b0, r_ovf_cnt, r_wm, 3'b0, 5'(r_cnt), 2'b0, r_ovf, w_empty};
      for (int k = 0; k < NFILT; k++) begin
        if (bus.rs == 5'(8 + 2 * k)) w_q = {r_fen[k], r_fext[k], 1'b0, r_fid[k]};
        if (bus.rs == 5'(9 + 2 * k)) w_q = {1'b0, r_fextm[k], 1'b0, r_fmask[k]};
      end
    end
  end
  assign bus.q   = w_q;
  assign bus.irq = (r_irqen[0] & ~w_empty) | (r_irqen[1] & r_ovf)
                 | (r_irqen[2] & (r_wm != 4'd0) & (8'(r_cnt) >= 8'(r_wm)));
endmodule
